// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider for DIV/DIVU/DDIV/DDIVU (quotient -> lo, remainder -> hi).
// Define DIV_RADIX4_EN to retire two quotient bits per phi2 cycle instead of one.
//
// state | meaning
// IDLE  | waiting for divgo, operands/mode latched on accept
// PREP  | absolute values, sign flags, iteration counter load
// ITER  | one (or two) restoring steps per phi2 cycle
// FIX   | sign correction, 32-bit sign extension, lo/hi write, divdone
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        phi2,
   input  logic        divgo,
   input  logic        divsigned,
   input  logic        divdword,
   input  logic [63:0] dividend,
   input  logic [63:0] divisor,
   output logic        divbusy,
   output logic        divdone,
   output logic [63:0] lo,
   output logic [63:0] hi
);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [5:0]  r_cnt;
   logic        r_done;
   logic        r_signed;
   logic        r_dword;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [63:0] r_dd;
   logic [63:0] r_dv_raw;
   logic [63:0] r_dv;
   logic [63:0] r_rem;
   logic [63:0] r_q;
   logic [63:0] r_lo;
   logic [63:0] r_hi;

   logic        w_dd_neg;
   logic        w_dv_neg;
   logic [63:0] w_dd_abs;
   logic [63:0] w_dv_abs;
   logic [127:0] w_step1;
   logic [127:0] w_step;
   logic [63:0] w_qn;
   logic [63:0] w_rn;
   logic [63:0] w_lo;
   logic [63:0] w_hi;

   // The remainder shift is done at 65 bits so divisors with bit 63 set still divide correctly.
   function automatic logic [127:0] div_step(input logic [63:0] rem, input logic [63:0] q,
                                             input logic [63:0] dv);
      logic [64:0] sh;
      logic [64:0] tr;
      sh = {rem, q[63]};
      tr = sh - {1'b0, dv};
      if (!tr[64])
         div_step = {tr[63:0], q[62:0], 1'b1};
      else
         div_step = {sh[63:0], q[62:0], 1'b0};
   endfunction

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else if (phi2)
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (divgo) w_next = S_PREP;
         S_PREP:  w_next = S_ITER;
         S_ITER:  if (r_cnt == 6'd0) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      divbusy = (r_state != S_IDLE);
      divdone = r_done;
      lo      = r_lo;
      hi      = r_hi;
   end

   // Two's-complement negation of the full word also yields the correct low 32 bits.
   always_comb begin
      w_dd_neg = r_signed & (r_dword ? r_dd[63] : r_dd[31]);
      w_dv_neg = r_signed & (r_dword ? r_dv_raw[63] : r_dv_raw[31]);
      w_dd_abs = w_dd_neg ? (~r_dd + 64'd1) : r_dd;
      w_dv_abs = w_dv_neg ? (~r_dv_raw + 64'd1) : r_dv_raw;
   end

   always_comb begin
      w_step1 = div_step(r_rem, r_q, r_dv);
`ifdef DIV_RADIX4_EN
      w_step  = div_step(w_step1[127:64], w_step1[63:0], r_dv);
`else
      w_step  = w_step1;
`endif
   end

   always_comb begin
      w_qn = r_neg_q ? (~r_q + 64'd1) : r_q;
      w_rn = r_neg_r ? (~r_rem + 64'd1) : r_rem;
      w_lo = r_dword ? w_qn : {{32{w_qn[31]}}, w_qn[31:0]};
      w_hi = r_dword ? w_rn : {{32{w_rn[31]}}, w_rn[31:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= 6'd0;
         r_done   <= 1'b0;
         r_signed <= 1'b0;
         r_dword  <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dd     <= 64'd0;
         r_dv_raw <= 64'd0;
         r_dv     <= 64'd0;
         r_rem    <= 64'd0;
         r_q      <= 64'd0;
         r_lo     <= 64'd0;
         r_hi     <= 64'd0;
      end else if (phi2) begin
         r_done <= (r_state == S_FIX);
         case (r_state)
            S_IDLE: begin
               if (divgo) begin
                  r_signed <= divsigned;
                  r_dword  <= divdword;
                  r_dd     <= dividend;
                  r_dv_raw <= divisor;
               end
            end
            S_PREP: begin
               r_neg_q <= w_dd_neg ^ w_dv_neg;
               r_neg_r <= w_dd_neg;
               r_rem   <= 64'd0;
               // 32-bit dividends sit in the top half so the quotient MSB is always r_q[63].
               r_q     <= r_dword ? w_dd_abs : {w_dd_abs[31:0], 32'd0};
               r_dv    <= r_dword ? w_dv_abs : {32'd0, w_dv_abs[31:0]};
`ifdef DIV_RADIX4_EN
               r_cnt   <= r_dword ? 6'd31 : 6'd15;
`else
               r_cnt   <= r_dword ? 6'd63 : 6'd31;
`endif
            end
            S_ITER: begin
               r_rem <= w_step[127:64];
               r_q   <= w_step[63:0];
               r_cnt <= r_cnt - 6'd1;
            end
            S_FIX: begin
               r_lo <= w_lo;
               r_hi <= w_hi;
            end
            default: ;
         endcase
      end
   end

endmodule
